// File: rtl/int_pkg.sv
// Shared definitions for the external interrupt controller.
// State encoding and default sizing used by int_controller and prio_enc.
package int_pkg;

    localparam int NUM_IRQ_DEF = 8;
    localparam int IDX_W_DEF   = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t REQ     = 2'd1;
    localparam state_t SERVICE = 2'd2;

endpackage

// File: rtl/int_controller_prio_enc.sv
// Combinational lowest-set-bit encoder; index 0 has the highest priority.
// valid is high whenever any eligible bit is set.
module prio_enc
    import int_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic [NUM_IRQ-1:0] eligible,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                index = IDX_W'(i);
            end
        end
    end

    assign valid = |eligible;

endmodule

// File: rtl/int_controller.sv
// External interrupt controller feeding the fetch stage: edge capture,
// masking, fixed priority selection and single-level in-service tracking.
module int_controller
    import int_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               rti,
    output logic               int_flag,
    output logic [IDX_W-1:0]   int_index,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask
);

    state_t             state;
    state_t             state_nxt;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] eligible;
    logic [IDX_W-1:0]   sel;
    logic               sel_valid;
    logic               flag_nxt;
    logic               svc_nxt;
    logic [IDX_W-1:0]   idx_nxt;

    assign rise     = irq_in & ~irq_prev;
    assign eligible = pending & ~mask;

    prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .eligible (eligible),
        .index    (sel),
        .valid    (sel_valid)
    );

    // Set beats clear when both hit the same bit in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= '0;
        end else begin
            irq_prev <= irq_in;
            pending  <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            int_flag   <= 1'b0;
            int_index  <= '0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            int_flag   <= flag_nxt;
            int_index  <= idx_nxt;
            in_service <= svc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sel_valid) state_nxt = REQ;
            REQ:     if (int_ack)   state_nxt = SERVICE;
            SERVICE: if (rti)       state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // A request is frozen once raised: no preemption, no withdrawal.
    always_comb begin
        flag_nxt = int_flag;
        idx_nxt  = int_index;
        svc_nxt  = in_service;
        clr      = '0;
        unique case (state)
            IDLE: begin
                if (sel_valid) begin
                    flag_nxt = 1'b1;
                    idx_nxt  = sel;
                end
            end
            REQ: begin
                if (int_ack) begin
                    flag_nxt = 1'b0;
                    svc_nxt  = 1'b1;
                    clr      = NUM_IRQ'(1) << int_index;
                end
            end
            SERVICE: begin
                if (rti) begin
                    svc_nxt = 1'b0;
                end
            end
            default: begin
                flag_nxt = 1'b0;
                svc_nxt  = 1'b0;
            end
        endcase
    end

endmodule
